// File: rtl/control_sumador_rizado_pkg.sv
// rtl/control_sumador_rizado_pkg.sv - shared types and constants for the ripple-adder sequencer
// State encodings, data width and default settle time used by all files of the block.
package control_sumador_rizado_pkg;

   localparam int DATA_W     = 8;
   localparam int SETTLE_DEF = 2;
   localparam int CNT_BITS   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/control_sumador_rizado_if.sv
// rtl/control_sumador_rizado_if.sv - operand, adder and result signal bundle
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface control_sumador_rizado_if #(
   parameter int CNT_W = 16
);
   import control_sumador_rizado_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_ci;
   logic              acc_mode;
   logic              acc_clear;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic              add_ci;
   logic [DATA_W-1:0] add_s;
   logic              add_co;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_s;
   logic              out_co;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  co_count;

   modport slave (
      input  in_valid, in_a, in_b, in_ci, acc_mode, acc_clear, add_s, add_co, out_ready,
      output in_ready, add_a, add_b, add_ci, out_valid, out_s, out_co, acc, co_count
   );

   modport master (
      output in_valid, in_a, in_b, in_ci, acc_mode, acc_clear, add_s, add_co, out_ready,
      input  in_ready, add_a, add_b, add_ci, out_valid, out_s, out_co, acc, co_count
   );

endinterface

// File: rtl/control_sumador_rizado_contador.sv
// rtl/control_sumador_rizado_contador.sv - 4-bit loadable down-counter with zero flag
// The zero flag lags the count by one cycle, giving the carry chain a margin cycle before sampling.
module contador_asentamiento
   import control_sumador_rizado_pkg::*;
(
   input  logic                clk,
   input  logic                reset_L,
   input  logic                i_load,
   input  logic [CNT_BITS-1:0] i_load_val,
   input  logic                i_dec,
   output logic                o_zero
);

   logic [CNT_BITS-1:0] r_cnt;
   logic                r_zero;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_cnt  <= '0;
         r_zero <= 1'b0;
      end else if (i_load) begin
         r_cnt  <= i_load_val;
         r_zero <= 1'b0;
      end else if (i_dec) begin
         r_cnt  <= (r_cnt == '0) ? '0 : r_cnt - CNT_BITS'(1);
         r_zero <= (r_cnt == '0);
      end
   end

   assign o_zero = r_zero;

endmodule

// File: rtl/control_sumador_rizado.sv
// rtl/control_sumador_rizado.sv - sequencer feeding an 8-bit ripple-carry adder
// Registers adder operands, waits for the carry chain to settle, then presents s/co downstream.
module control_sumador_rizado
   import control_sumador_rizado_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_DEF,
   parameter int CNT_W         = 16
) (
   input  logic                    clk,
   input  logic                    reset_L,
   control_sumador_rizado_if.slave bus
);

   state_t              r_state;
   state_t              w_next;
   logic                w_in_ready;
   logic                w_accept;
   logic                w_capture;
   logic                w_zero;
   logic                w_dec;
   logic [CNT_BITS-1:0] w_load_val;
   logic [DATA_W-1:0]   w_acc_eff;

   logic [DATA_W-1:0]   r_add_a;
   logic [DATA_W-1:0]   r_add_b;
   logic                r_add_ci;
   logic [DATA_W-1:0]   r_out_s;
   logic                r_out_co;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_acc;
   logic                r_acc_mode;
   logic [CNT_W-1:0]    r_co_count;

   always_ff @(posedge clk) begin
      if (!reset_L) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = ST_SETTLE;
         ST_SETTLE: if (w_zero)   w_next = ST_HOLD;
         ST_HOLD:   if (bus.out_ready) w_next = w_accept ? ST_SETTLE : ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = 1'b0;
      w_accept   = 1'b0;
      w_capture  = 1'b0;
      w_dec      = 1'b0;
      if (reset_L)
         w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.out_ready);
      w_accept  = bus.in_valid && w_in_ready;
      w_dec     = (r_state == ST_SETTLE);
      w_capture = w_dec && w_zero;
   end

   assign w_load_val = CNT_BITS'(SETTLE_CYCLES - 1);

   contador_asentamiento u_contador (
      .clk        (clk),
      .reset_L    (reset_L),
      .i_load     (w_accept),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   // A clear in the accept cycle must already zero the fed-back operand.
   assign w_acc_eff = bus.acc_clear ? '0 : r_acc;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_add_ci    <= 1'b0;
         r_out_s     <= '0;
         r_out_co    <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_acc_mode  <= 1'b0;
         r_co_count  <= '0;
      end else begin
         if (w_accept) begin
            r_add_a    <= bus.acc_mode ? w_acc_eff : bus.in_a;
            r_add_b    <= bus.in_b;
            r_add_ci   <= bus.in_ci;
            r_acc_mode <= bus.acc_mode;
         end
         if (w_capture) begin
            r_out_s     <= bus.add_s;
            r_out_co    <= bus.add_co;
            r_out_valid <= 1'b1;
            if (bus.add_co && (r_co_count != {CNT_W{1'b1}}))
               r_co_count <= r_co_count + CNT_W'(1);
         end else if ((r_state == ST_HOLD) && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_capture && r_acc_mode) r_acc <= bus.add_s;
         else if (bus.acc_clear)      r_acc <= '0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.add_a     = r_add_a;
   assign bus.add_b     = r_add_b;
   assign bus.add_ci    = r_add_ci;
   assign bus.out_valid = r_out_valid;
   assign bus.out_s     = r_out_s;
   assign bus.out_co    = r_out_co;
   assign bus.acc       = r_acc;
   assign bus.co_count  = r_co_count;

endmodule

// File: tb/tb_control_sumador_rizado.sv
// tb/tb_control_sumador_rizado.sv - directed self-checking bench for control_sumador_rizado
// Three builds: default settle, SETTLE_CYCLES=1 with a 4-bit counter, and SETTLE_CYCLES=15.
module tb_control_sumador_rizado;
   import control_sumador_rizado_pkg::*;

   logic clk = 1'b0;
   logic reset_L;
   int   checks   = 0;
   int   failures = 0;
   int   lat;

   always #5 clk = ~clk;

   control_sumador_rizado_if #(.CNT_W(16)) b();
   control_sumador_rizado_if #(.CNT_W(4))  b1();
   control_sumador_rizado_if #(.CNT_W(16)) b15();

   assign {b.add_co, b.add_s}     = 9'(b.add_a) + 9'(b.add_b) + 9'(b.add_ci);
   assign {b1.add_co, b1.add_s}   = 9'(b1.add_a) + 9'(b1.add_b) + 9'(b1.add_ci);
   assign {b15.add_co, b15.add_s} = 9'(b15.add_a) + 9'(b15.add_b) + 9'(b15.add_ci);

   control_sumador_rizado #(.SETTLE_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset_L(reset_L), .bus(b.slave));
   control_sumador_rizado #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clk), .reset_L(reset_L), .bus(b1.slave));
   control_sumador_rizado #(.SETTLE_CYCLES(15), .CNT_W(16)) dut15 (
      .clk(clk), .reset_L(reset_L), .bus(b15.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] bb, input logic ci,
                     input logic m, input logic clr, output int l);
      b.in_a = a; b.in_b = bb; b.in_ci = ci; b.acc_mode = m; b.acc_clear = clr;
      b.in_valid = 1'b1;
      l = 0;
      while (!b.in_ready && l < 50) begin step(); l++; end
      step();
      b.in_valid = 1'b0; b.acc_mode = 1'b0;
      l = 0;
      while (!b.out_valid && l < 50) begin step(); l++; end
      b.acc_clear = 1'b0;
   endtask

   initial begin
      reset_L = 1'b0;
      {b.in_valid, b.in_a, b.in_b, b.in_ci, b.acc_mode, b.acc_clear} = '0;
      {b1.in_valid, b1.in_a, b1.in_b, b1.in_ci, b1.acc_mode, b1.acc_clear} = '0;
      {b15.in_valid, b15.in_a, b15.in_b, b15.in_ci, b15.acc_mode, b15.acc_clear} = '0;
      b.out_ready = 1'b1; b1.out_ready = 1'b1; b15.out_ready = 1'b1;

      // reset state
      step();
      chk("rst_in_ready", b.in_ready, 0);
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_add_a", b.add_a, 0);
      chk("rst_add_b", b.add_b, 0);
      chk("rst_add_ci", b.add_ci, 0);
      chk("rst_out_s", b.out_s, 0);
      chk("rst_acc", b.acc, 0);
      chk("rst_co_count", b.co_count, 0);
      reset_L = 1'b1;
      #1;
      chk("idle_in_ready", b.in_ready, 1);

      // basic add, operands stable through the settle window
      b.in_a = 8'h35; b.in_b = 8'h4A; b.in_ci = 1'b0; b.in_valid = 1'b1;
      step();
      b.in_valid = 1'b0;
      chk("basic_add_a", b.add_a, 8'h35);
      chk("basic_add_b", b.add_b, 8'h4A);
      chk("basic_ov_e1", b.out_valid, 0);
      step();
      chk("basic_ov_e2", b.out_valid, 0);
      chk("basic_add_a_stable", b.add_a, 8'h35);
      step();
      chk("basic_ov_e3", b.out_valid, 0);
      chk("basic_add_b_stable", b.add_b, 8'h4A);
      step();
      chk("basic_ov_lat3", b.out_valid, 1);
      chk("basic_out_s", b.out_s, 8'h7F);
      chk("basic_out_co", b.out_co, 0);
      step();
      chk("basic_consumed", b.out_valid, 0);

      // carry / overflow
      op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, lat);
      chk("carry_lat", lat, 3);
      chk("carry_out_s", b.out_s, 8'h01);
      chk("carry_out_co", b.out_co, 1);
      chk("carry_co_count", b.co_count, 1);
      step();

      // backpressure then overlapped accept
      b.out_ready = 1'b0;
      op(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, lat);
      chk("bp_lat", lat, 3);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", b.out_valid, 1);
         chk("bp_hold_s", b.out_s, 8'h33);
         chk("bp_hold_co", b.out_co, 0);
         chk("bp_in_ready", b.in_ready, 0);
      end
      b.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", b.in_ready, 1);
      op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, lat);
      chk("b2b_lat", lat, 3);
      chk("b2b_out_s", b.out_s, 8'h30);
      step();

      // accumulate mode
      op(8'h00, 8'h80, 1'b0, 1'b1, 1'b0, lat);
      chk("acc1_s", b.out_s, 8'h80);
      chk("acc1_acc", b.acc, 8'h80);
      op(8'h00, 8'h80, 1'b0, 1'b1, 1'b0, lat);
      chk("acc2_acc", b.acc, 8'h00);
      chk("acc2_co", b.out_co, 1);
      op(8'h00, 8'h80, 1'b0, 1'b1, 1'b0, lat);
      chk("acc3_acc", b.acc, 8'h80);
      chk("acc_co_count", b.co_count, 2);
      step();
      b.acc_clear = 1'b1;
      step();
      b.acc_clear = 1'b0;
      chk("acc_clear_alone", b.acc, 8'h00);
      op(8'h00, 8'h33, 1'b0, 1'b1, 1'b0, lat);
      chk("acc4_acc", b.acc, 8'h33);
      op(8'h99, 8'h05, 1'b0, 1'b1, 1'b1, lat);
      chk("clr_accept_add_a", b.add_a, 8'h00);
      chk("clr_accept_s", b.out_s, 8'h05);
      chk("clr_capture_wins", b.acc, 8'h05);
      step();

      // reset one cycle after accept
      b.in_a = 8'h44; b.in_b = 8'h11; b.in_valid = 1'b1;
      step();
      b.in_valid = 1'b0;
      step();
      reset_L = 1'b0;
      step();
      chk("midrst_out_valid", b.out_valid, 0);
      chk("midrst_add_a", b.add_a, 0);
      chk("midrst_add_b", b.add_b, 0);
      chk("midrst_out_s", b.out_s, 0);
      chk("midrst_acc", b.acc, 0);
      chk("midrst_co_count", b.co_count, 0);
      chk("midrst_in_ready", b.in_ready, 0);
      reset_L = 1'b1;
      #1;
      chk("midrst_idle", b.in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("midrst_no_result", b.out_valid, 0);
      end
      op(8'h02, 8'h03, 1'b0, 1'b0, 1'b0, lat);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_s", b.out_s, 8'h05);
      step();

      // SETTLE_CYCLES=1 build with saturating 4-bit carry counter
      for (int i = 0; i < 16; i++) begin
         b1.in_a = 8'hFF; b1.in_b = 8'h01; b1.in_ci = 1'b0; b1.in_valid = 1'b1;
         lat = 0;
         while (!b1.in_ready && lat < 50) begin step(); lat++; end
         step();
         b1.in_valid = 1'b0;
         lat = 0;
         while (!b1.out_valid && lat < 50) begin step(); lat++; end
         if (i == 0) begin
            chk("sc1_lat", lat, 2);
            chk("sc1_co_count_first", b1.co_count, 1);
         end
         if (i == 14) chk("sc1_co_count_15", b1.co_count, 4'hF);
      end
      chk("sc1_co_count_sat", b1.co_count, 4'hF);
      chk("sc1_out_s", b1.out_s, 8'h00);
      chk("sc1_out_co", b1.out_co, 1);

      // SETTLE_CYCLES=15 build
      b15.in_a = 8'h12; b15.in_b = 8'h34; b15.in_ci = 1'b1; b15.in_valid = 1'b1;
      step();
      b15.in_valid = 1'b0;
      lat = 0;
      while (!b15.out_valid && lat < 50) begin step(); lat++; end
      chk("sc15_lat", lat, 16);
      chk("sc15_out_s", b15.out_s, 8'h47);
      chk("sc15_out_co", b15.out_co, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
